divdiv: RTL and testbench
=========================

Name: divdiv

Overview:
- Multi-cycle 32-bit integer divider: the inverse companion of the pipelined multiplier in the execute stage. Serves MIPS DIV/DIVU.
- Same valid/done handshake as the multiplier, so the execute-stage stall logic treats both units the same way.
- Result packs remainder (HI) and quotient (LO) into one i64, the layout the HI/LO write-back expects.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- None. Width is fixed at 32 by the i32/i64 typedefs in mycpu/defs.svh.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- valid  input  1  request; sampled only while the unit is IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured at acceptance
- a  input  32 (i32)  dividend; captured at acceptance
- b  input  32 (i32)  divisor; captured at acceptance
- done  output  1  combinational; high when state_nxt == IDLE
- c  output  64 (i64)  c[63:32] = remainder, c[31:0] = quotient; meaningful only while done is high in FIX

Behaviour:
- Reset: asynchronous, active-low (resetn low clears immediately, without waiting for clk).
  - state = IDLE, iteration counter = 0, all datapath registers = 0, so c = 0.
  - done = 1 unless valid is high in IDLE.
- States: IDLE, DOING, FIX.
- IDLE
  - When valid = 1:
    - Latch |a| and |b| when is_signed, raw a and b otherwise.
    - Latch the two sign flags: quotient-negative = a[31] xor b[31]; remainder-negative = a[31]; both signed only.
    - Latch a divide-by-zero flag (b == 0).
    - Clear the remainder register and counter; go to DOING.
  - When valid = 0: stay in IDLE.
- DOING: one restoring step per cycle.
  - Form {rem[31:0], quot[31]}.
  - Subtract the 33-bit zero-extended divisor.
  - If the result is non-negative: rem takes the difference and the shifted-in quotient bit is 1.
  - Otherwise: rem takes the shifted value and the quotient bit is 0.
  - Quotient register shifts left.
  - Counter runs 0..31; at counter == 31, go to FIX.
- FIX: c is driven combinationally from the registers with sign correction applied.
  - Quotient negated if quotient-negative; remainder negated if remainder-negative.
  - Next state is IDLE, so done = 1 for this one cycle.
- Latency: valid accepted at the edge ending cycle T; done = 1 with a valid c in cycle T+33. 32 DOING cycles, then 1 FIX cycle.
- done is 0 in the IDLE accept cycle and throughout DOING.
- Divide-by-zero override, in both signed and unsigned modes:
  - quotient = 32'hFFFF_FFFF, remainder = the original a.
  - The iteration still runs 33 cycles; there is no early exit.
- Signed overflow, 32'h8000_0000 / 32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0. This is the natural result of the abs/negate path; no special case.
- Operand and control changes after acceptance:
  - a, b and is_signed are ignored after acceptance.
  - valid dropping during DOING or FIX does not abort the operation.
- Back-to-back requests: if valid is still high in the cycle after FIX, the unit is back in IDLE and accepts it as a new request. The requester must drop valid after seeing done if it does not want a repeat.
- Reset mid-operation: immediate return to IDLE with c = 0; no partial result is ever exposed.
- c outside FIX shows the raw register contents and carries no meaning. A bench checks c only when state is FIX, that is, when done is high after a busy period.

Decomposition:
- defs package: reuse i32 and i64. Add the shared enum div_state_t {IDLE, DOING, FIX}.
- Add the constant DIV_ITERS = 32 to the package.
- No sub-module: the restoring step is a single 33-bit subtract, kept inline.

Test Plan:
- Unsigned 100 / 7, is_signed = 0 -> done at T+33, c = {32'd2, 32'd14}; done = 0 from T through T+32.
- Signed -7 / 2, a = 32'hFFFF_FFF9 -> c = {32'hFFFF_FFFF, 32'hFFFF_FFFD} (r = -1, q = -3).
- Signed 7 / -2 -> c = {32'd1, 32'hFFFF_FFFD}.
- Divide by zero: unsigned 5 / 0 -> c = {32'd5, 32'hFFFF_FFFF}; signed -5 / 0 -> c = {32'hFFFF_FFFB, 32'hFFFF_FFFF}.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF -> c = {32'h0, 32'h8000_0000}.
- Robustness, sequence:
  - Start 1000 / 10, then change a and b and drop valid at iteration 5 -> result is still {0, 100}.
  - Start another operation and pull resetn low at iteration 10, between clock edges -> state is IDLE, c = 0 and done = 1 immediately (without waiting for the next clk edge).
  - After resetn is released, 9 / 3 -> {0, 3}.

Source files
------------

// File: rtl/divdiv_pkg.sv
// Shared types for the divide unit: operand/result words, FSM states, iteration count.
// No logic; constants only.
// No handshake of its own.
package divdiv_pkg;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [1:0] {
    IDLE,
    DOING,
    FIX
  } div_state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

endpackage

// File: rtl/divdiv.sv
// Multi-cycle radix-2 restoring 32-bit divider for DIV/DIVU; c = {remainder, quotient}.
// Latency: request accepted at the edge ending cycle T, result valid with done in cycle T+33.
// Backpressure: valid is sampled only in IDLE; the unit is busy (done = 0) until its FIX cycle.
module divdiv
  import divdiv_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic valid,
  input  logic is_signed,
  input  i32   a,
  input  i32   b,
  output logic done,
  output i64   c
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  i32               rem;
  i32               quot;
  i32               dvs;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;

  i32               a_abs;
  i32               b_abs;
  logic [32:0]      shifted;
  logic [32:0]      diff;
  logic             step_ge;
  i32               q_fix;
  i32               r_fix;

  // Operand magnitudes used only in signed mode.
  assign a_abs = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign b_abs = (is_signed && b[31]) ? (32'd0 - b) : b;

  // One restoring step. Because rem < dvs holds between steps, the shifted value is
  // below 2*dvs, so bit 32 of the 33-bit difference is a true sign bit. With a zero
  // divisor the difference equals the shifted value, so rem still just shifts (and
  // ends up holding the dividend); the quotient is overridden in FIX.
  assign shifted = {rem, quot[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign step_ge = ~diff[32];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = DOING;
      DOING:   if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    done = (state_nxt == IDLE);
  end

  // Operand capture at acceptance, then one quotient bit per DOING cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      rem   <= '0;
      quot  <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            quot  <= a_abs;
            dvs   <= b_abs;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= is_signed & (a[31] ^ b[31]);
            r_neg <= is_signed & a[31];
            dbz   <= (b == 32'd0);
          end
        end
        DOING: begin
          rem  <= step_ge ? diff[31:0] : shifted[31:0];
          quot <= {quot[30:0], step_ge};
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result: sign-corrected in FIX. For divide-by-zero the remainder path already
  // reproduces the original a (magnitude, then re-negated if a was negative).
  always_comb begin
    q_fix = dbz ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - quot) : quot);
    r_fix = r_neg ? (32'd0 - rem) : rem;
    c     = {rem, quot};
    if (state == FIX) begin
      c = {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_divdiv.sv
// Self-checking bench for divdiv: directed cases, robustness sequence, randomized ops.
// Expected results come from plain integer arithmetic in ref_div.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_divdiv;
  import divdiv_pkg::*;

  logic clk       = 1'b0;
  logic resetn    = 1'b0;
  logic valid     = 1'b0;
  logic is_signed = 1'b0;
  i32   a         = '0;
  i32   b         = '0;
  logic done;
  i64   c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divdiv dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .done      (done),
    .c         (c)
  );

  // Reference: MIPS DIV/DIVU semantics with plain arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [31:0] qw;
    logic [31:0] rw;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      qw = q[31:0];
      rw = r[31:0];
    end else begin
      qw = x / y;
      rw = x % y;
    end
    return {rw, qw};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request in the current cycle; hold valid for 'hold' cycles after
  // acceptance, then drop it and scramble the operand inputs.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_in, input logic ts,
                        input int hold, input string tag);
    logic [63:0] exp;
    int busy_bad;
    exp      = ref_div(ta, tb_in, ts);
    busy_bad = 0;
    @(negedge clk);
    a = ta; b = tb_in; is_signed = ts; valid = 1'b1;
    #1;
    chk({tag, "_accept_done"}, 64'(done), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i >= hold) begin
        valid = 1'b0; a = $urandom; b = $urandom; is_signed = ~ts;
      end
      #1;
      if (done !== 1'b0) busy_bad++;
    end
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_c"}, c, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          mode;

    // Reset state.
    #1;
    chk("rst_c", c, 64'd0);
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(32'd100, 32'd7, 1'b0, 1, "u100_7");
    chk("u100_7_ref", c, {32'd2, 32'd14});
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1, "s_m7_2");
    chk("s_m7_2_ref", c, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, "s7_m2");
    chk("s7_m2_ref", c, {32'd1, 32'hFFFF_FFFD});
    run_op(32'd5, 32'd0, 1'b0, 1, "u5_0");
    chk("u5_0_ref", c, {32'd5, 32'hFFFF_FFFF});
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1, "s_m5_0");
    chk("s_m5_0_ref", c, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, "s_ovf");
    chk("s_ovf_ref", c, {32'h0, 32'h8000_0000});
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1, "u_max_1");

    // Operand/valid changes during DOING are ignored.
    run_op(32'd1000, 32'd10, 1'b0, 5, "hold5");
    chk("hold5_ref", c, {32'd0, 32'd100});

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 32'd12345; b = 32'd17; is_signed = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_rst_state", 64'(dut.state), 64'(IDLE));
    chk("mid_rst_c", c, 64'd0);
    chk("mid_rst_done", 64'(done), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, 1, "post_rst");
    chk("post_rst_ref", c, {32'd0, 32'd3});

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      ra   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'd0 - 32'($urandom_range(1, 15));
        default: rb = (n % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      run_op(ra, rb, rs, 1, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
